rv32i_pipeline_ctrl: RTL

// Central stall/flush sequencer for the 5-stage core (fetch, decode, execute, memory, writeback).

---
 rtl/rv32i_pkg.sv | 13 +
 rtl/rv32i_hazard_detect.sv | 17 +
 rtl/rv32i_pipeline_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared core definitions: pipeline control state encodings and architectural constants
// used by the stall/flush sequencer and the forwarding unit.
package rv32i_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/rv32i_hazard_detect.sv
// Load-use hazard comparator: flags a decode-stage source register that matches the
// destination of a LOAD still sitting in execute. x0 never creates a dependency.
module rv32i_hazard_detect
  import rv32i_pkg::*;
(
  input  logic [4:0] rs1_addr_d,
  input  logic [4:0] rs2_addr_d,
  input  logic [4:0] rd_addr_x,
  input  logic       opcode_load_x,
  input  logic       valid_x,
  output logic       load_use
);

  assign load_use = valid_x & opcode_load_x & (rd_addr_x != REG_ZERO) &
                    ((rd_addr_x == rs1_addr_d) | (rd_addr_x == rs2_addr_d));

endmodule

// File: rtl/rv32i_pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage core: turns hazards, memory wait states and
// redirects into per-stage hold/bubble controls, and counts stalled cycles.
module rv32i_pipeline_ctrl
  import rv32i_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [4:0]           i_rs1_addr_d,
  input  logic [4:0]           i_rs2_addr_d,
  input  logic [4:0]           i_rd_addr_x,
  input  logic                 i_opcode_load_x,
  input  logic                 i_valid_x,
  input  logic                 i_change_pc,
  input  logic                 i_imem_stall,
  input  logic                 i_dmem_stall,
  output logic                 o_hold_fetch,
  output logic                 o_hold_decode,
  output logic                 o_hold_execute,
  output logic                 o_hold_memory,
  output logic                 o_bubble_decode,
  output logic                 o_bubble_execute,
  output logic                 o_bubble_wb,
  output logic [1:0]           o_state,
  output logic [CNT_WIDTH-1:0] o_stall_cnt
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  ctrl_state_e          state, state_next;
  logic [2:0]           flush_cnt, flush_cnt_next;
  logic                 redirect_pending, pending_next;
  logic                 load_use;
  logic                 hold_f, hold_d, hold_x, hold_m;
  logic                 bub_d, bub_x, bub_wb;
  logic                 any_hold;
  logic [CNT_WIDTH-1:0] stall_cnt;

  rv32i_hazard_detect u_hazard (
    .rs1_addr_d    (i_rs1_addr_d),
    .rs2_addr_d    (i_rs2_addr_d),
    .rd_addr_x     (i_rd_addr_x),
    .opcode_load_x (i_opcode_load_x),
    .valid_x       (i_valid_x),
    .load_use      (load_use)
  );

  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    pending_next   = redirect_pending;
    hold_f         = 1'b0;
    hold_d         = 1'b0;
    hold_x         = 1'b0;
    hold_m         = 1'b0;
    bub_d          = 1'b0;
    bub_x          = 1'b0;
    bub_wb         = 1'b0;
    if (i_dmem_stall) begin
      // Execute is frozen, so a redirect resolved now must survive until the stall ends.
      hold_f       = 1'b1;
      hold_d       = 1'b1;
      hold_x       = 1'b1;
      hold_m       = 1'b1;
      bub_wb       = 1'b1;
      state_next   = MEM_WAIT;
      pending_next = redirect_pending | i_change_pc;
    end else if (i_change_pc || redirect_pending) begin
      bub_d        = 1'b1;
      bub_x        = 1'b1;
      pending_next = 1'b0;
      if (FLUSH_CYCLES > 1) begin
        state_next     = FLUSH;
        flush_cnt_next = FLUSH_LOAD;
      end else begin
        state_next = RUN;
      end
    end else if (state == FLUSH) begin
      bub_d          = 1'b1;
      bub_x          = 1'b1;
      flush_cnt_next = flush_cnt - 3'd1;
      if (flush_cnt <= 3'd1) begin
        state_next = RUN;
      end
    end else begin
      state_next = RUN;
      if (load_use) begin
        hold_f = 1'b1;
        hold_d = 1'b1;
        bub_x  = 1'b1;
      end else if (i_imem_stall) begin
        hold_f = 1'b1;
        bub_d  = 1'b1;
      end
    end
  end

  assign any_hold = hold_f | hold_d | hold_x | hold_m;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state            <= RUN;
      flush_cnt        <= 3'd0;
      redirect_pending <= 1'b0;
      stall_cnt        <= '0;
    end else begin
      state            <= state_next;
      flush_cnt        <= flush_cnt_next;
      redirect_pending <= pending_next;
      if (any_hold && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign o_hold_fetch     = i_rst_n & hold_f;
  assign o_hold_decode    = i_rst_n & hold_d;
  assign o_hold_execute   = i_rst_n & hold_x;
  assign o_hold_memory    = i_rst_n & hold_m;
  assign o_bubble_decode  = i_rst_n & bub_d;
  assign o_bubble_execute = i_rst_n & bub_x;
  assign o_bubble_wb      = i_rst_n & bub_wb;
  assign o_state          = state;
  assign o_stall_cnt      = stall_cnt;

endmodule
